// File: rtl/quad_encoder_pkg.sv
// ---------------------------------------------------------------------------
// quad_encoder_pkg
//   Shared widths, quadrature state encodings and the velocity saturation
//   helper for the quadrature encoder front end.
// ---------------------------------------------------------------------------
package quad_encoder_pkg;

  localparam int unsigned POS_W = 32;
  localparam int unsigned VEL_W = 16;
  localparam int unsigned ERR_W = 16;

  // Quadrature states, ab = {B, A}. Walking S0->S1->S2->S3->S0 means A leads B.
  localparam logic [1:0] AB_S0 = 2'b00;
  localparam logic [1:0] AB_S1 = 2'b01;
  localparam logic [1:0] AB_S2 = 2'b11;
  localparam logic [1:0] AB_S3 = 2'b10;

  localparam logic signed [VEL_W-1:0] VEL_MAX = 16'sh7FFF;
  localparam logic signed [VEL_W-1:0] VEL_MIN = 16'sh8000;

  // Clamp a wrapped 32-bit count difference into the signed velocity range.
  function automatic logic signed [VEL_W-1:0] sat_vel(input logic signed [POS_W-1:0] d);
    logic signed [VEL_W-1:0] r;
    if (d > 32'sd32767)
      r = VEL_MAX;
    else if (d < -32'sd32768)
      r = VEL_MIN;
    else
      r = d[VEL_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/encoder_input_sync.sv
// ---------------------------------------------------------------------------
// encoder_input_sync
//   Multi-stage flip-flop synchronizer for one asynchronous encoder line.
//   Ports:
//     clock   - system clock
//     reset_n - asynchronous active-low reset (chain clears to 0)
//     raw     - asynchronous input
//     synced  - input delayed by SYNC_STAGES clocks, safe to use in clock domain
// ---------------------------------------------------------------------------
module encoder_input_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw,
  output logic synced
);

  logic [SYNC_STAGES-1:0] stages;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      stages <= '0;
    else
      stages <= {stages[SYNC_STAGES-2:0], raw};
  end

  assign synced = stages[SYNC_STAGES-1];

endmodule

// File: rtl/quad_encoder_frontend.sv
// ---------------------------------------------------------------------------
// quad_encoder_frontend
//   Quadrature encoder decoder feeding the PID controller. Produces a 32-bit
//   wrapping position count, a saturated per-period velocity, and a
//   one-cycle update_controller strobe every CLK_DIV clocks; position and
//   velocity change only on that strobe so they always form a coherent pair.
//
//   Ports:
//     clock             - system clock
//     reset_n           - asynchronous active-low reset
//     enc_a, enc_b      - encoder channels, asynchronous to clock
//     zero_position     - synchronous request to clear the running count
//     enc_i, index_arm  - index channel and arm pulse (ENCODER_INDEX_EN only)
//     position          - signed count sampled at the last strobe
//     velocity          - signed counts per period, saturated to 16 bits
//     update_controller - one-cycle strobe, outputs fresh
//     illegal_count     - saturating count of illegal A/B transitions
//
//   Build option: define ENCODER_INDEX_EN to add the index-pulse zeroing
//   logic and its two ports.
// ---------------------------------------------------------------------------
module quad_encoder_frontend
  import quad_encoder_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 50000,
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          INVERT_DIR  = 1'b0
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    enc_a,
  input  logic                    enc_b,
  input  logic                    zero_position,
`ifdef ENCODER_INDEX_EN
  input  logic                    enc_i,
  input  logic                    index_arm,
`endif
  output logic signed [POS_W-1:0] position,
  output logic signed [VEL_W-1:0] velocity,
  output logic                    update_controller,
  output logic [ERR_W-1:0]        illegal_count
);

  localparam int unsigned DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic                    a_sync;
  logic                    b_sync;
  logic [1:0]              ab;
  logic [1:0]              prev_ab;
  logic signed [1:0]       step;
  logic                    illegal;
  logic signed [POS_W-1:0] step_ext;
  logic signed [POS_W-1:0] count;
  logic signed [POS_W-1:0] reference;
  logic signed [POS_W-1:0] next_count;
  logic signed [POS_W-1:0] ref_eff;
  logic signed [POS_W-1:0] delta;
  logic [DIV_W-1:0]        div;
  logic                    terminal;
  logic                    index_hit;
  logic                    clear;

  encoder_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_a (
    .clock  (clock),
    .reset_n(reset_n),
    .raw    (enc_a),
    .synced (a_sync)
  );

  encoder_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_b (
    .clock  (clock),
    .reset_n(reset_n),
    .raw    (enc_b),
    .synced (b_sync)
  );

  // B in the high bit so that A leading B walks the state order upward.
  assign ab = {b_sync, a_sync};

`ifdef ENCODER_INDEX_EN
  logic i_sync;
  logic prev_i;
  logic armed;

  encoder_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_i (
    .clock  (clock),
    .reset_n(reset_n),
    .raw    (enc_i),
    .synced (i_sync)
  );

  assign index_hit = armed & i_sync & ~prev_i;

  // An arm pulse wins over a simultaneous hit so the next edge is not missed.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_i <= 1'b0;
      armed  <= 1'b0;
    end else begin
      prev_i <= i_sync;
      if (index_arm)
        armed <= 1'b1;
      else if (index_hit)
        armed <= 1'b0;
    end
  end
`else
  assign index_hit = 1'b0;
`endif

  assign clear = zero_position | index_hit;

  // 4x decode of the previous/current state pair.
  always_comb begin
    step    = 2'sb00;
    illegal = 1'b0;
    case ({prev_ab, ab})
      {AB_S0, AB_S1}, {AB_S1, AB_S2}, {AB_S2, AB_S3}, {AB_S3, AB_S0}:
        step = INVERT_DIR ? 2'sb11 : 2'sb01;
      {AB_S1, AB_S0}, {AB_S2, AB_S1}, {AB_S3, AB_S2}, {AB_S0, AB_S3}:
        step = INVERT_DIR ? 2'sb01 : 2'sb11;
      default:
        illegal = ((prev_ab ^ ab) == 2'b11);
    endcase
  end

  assign step_ext = {{(POS_W-2){step[1]}}, step};
  assign terminal = (div == DIV_LAST);

  // A clear zeroes both the count and the reference, so a clear landing on
  // the terminal cycle naturally yields position 0 and velocity 0.
  assign next_count = clear ? '0 : count + step_ext;
  assign ref_eff    = clear ? '0 : reference;
  assign delta      = next_count - ref_eff;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_ab           <= AB_S0;
      count             <= '0;
      reference         <= '0;
      div               <= '0;
      position          <= '0;
      velocity          <= '0;
      update_controller <= 1'b0;
      illegal_count     <= '0;
    end else begin
      prev_ab           <= ab;
      count             <= next_count;
      update_controller <= terminal;
      if (terminal) begin
        div       <= '0;
        position  <= next_count;
        velocity  <= sat_vel(delta);
        reference <= next_count;
      end else begin
        div <= div + DIV_W'(1);
        if (clear)
          reference <= '0;
      end
      if (illegal && (illegal_count != '1))
        illegal_count <= illegal_count + ERR_W'(1);
    end
  end

endmodule
